// File: rtl/main_memory_responder.sv
// Main-memory model below the L2: fixed-latency line fills and single-cycle write-backs.
// Requests are serviced through IDLE -> WAIT -> RESP; a request dropped during WAIT exits via DRAIN.
module main_memory_responder #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 8,
  parameter int IDX_W   = 2,
  parameter int DATA_W  = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            req,
  input  logic [2:0]                      req_addr,
  input  logic [TAG_W-1:0]                req_tag,
  output logic [TAG_W+DATA_W-1:0]         resp_line,
  output logic                            resp_valid,
  output logic                            busy,
  input  logic                            wb_valid,
  input  logic [IDX_W+TAG_W+DATA_W-1:0]   wb_line,
  output logic                            wb_ack,
  output logic [7:0]                      rd_count,
  output logic [7:0]                      wb_count
);

  localparam int AW    = TAG_W + IDX_W;
  localparam int DEPTH = 1 << AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [AW-1:0]           cap_addr_q, cap_addr_d;
  logic [TAG_W+DATA_W-1:0] resp_line_q, resp_line_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    wb_ack_q, wb_ack_d;
  logic [7:0]              rd_count_q, rd_count_d;
  logic [7:0]              wb_count_q, wb_count_d;

  logic [IDX_W-1:0]  wb_idx;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic [AW-1:0]     wb_addr;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr_bits;

  assign wb_idx  = wb_line[DATA_W+TAG_W +: IDX_W];
  assign wb_tag  = wb_line[DATA_W +: TAG_W];
  assign wb_data = wb_line[DATA_W-1:0];
  assign wb_addr = {wb_tag, wb_idx};
  assign unused_addr_bits = ^req_addr;

  // Words are stored XORed with their low address bits, so a zero-initialised
  // array reads back as the power-up pattern mem[a] = a[DATA_W-1:0]. Not reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (wb_valid) mem_q[wb_addr] <= wb_data ^ wb_addr[DATA_W-1:0];
  end

  // Write-first: a same-cycle write-back to the captured address wins.
  always_comb begin
    rd_data = mem_q[cap_addr_q] ^ cap_addr_q[DATA_W-1:0];
    if (wb_valid && (wb_addr == cap_addr_q)) rd_data = wb_data;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cap_addr_d   = cap_addr_q;
    resp_line_d  = resp_line_q;
    resp_valid_d = resp_valid_q;
    rd_count_d   = rd_count_q;
    wb_ack_d     = wb_valid;
    wb_count_d   = wb_valid ? wb_count_q + 8'd1 : wb_count_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cap_addr_d = {req_tag, req_addr[IDX_W-1:0]};
          cnt_d      = 4'(LATENCY - 1);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_d = S_DRAIN;
        end else if (cnt_q == 4'd0) begin
          resp_line_d  = {cap_addr_q[AW-1:IDX_W], rd_data};
          resp_valid_d = 1'b1;
          rd_count_d   = rd_count_q + 8'd1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (!req) begin
          resp_line_d  = '0;
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cap_addr_q   <= '0;
      resp_line_q  <= '0;
      resp_valid_q <= 1'b0;
      wb_ack_q     <= 1'b0;
      rd_count_q   <= '0;
      wb_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cap_addr_q   <= cap_addr_d;
      resp_line_q  <= resp_line_d;
      resp_valid_q <= resp_valid_d;
      wb_ack_q     <= wb_ack_d;
      rd_count_q   <= rd_count_d;
      wb_count_q   <= wb_count_d;
    end
  end

  assign resp_line  = resp_line_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign wb_ack     = wb_ack_q;
  assign rd_count   = rd_count_q;
  assign wb_count   = wb_count_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: latency, write-back, forwarding, abort, async reset, wrap.
module tb_main_memory_responder;

  logic        clock, reset, req, wb_valid;
  logic [2:0]  req_addr;
  logic [7:0]  req_tag;
  logic [10:0] resp_line;
  logic        resp_valid, busy, wb_ack;
  logic [12:0] wb_line;
  logic [7:0]  rd_count, wb_count;

  int errors = 0;
  int checks = 0;

  main_memory_responder #(.LATENCY(2), .TAG_W(8), .IDX_W(2), .DATA_W(3)) dut (
    .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_tag(req_tag),
    .resp_line(resp_line), .resp_valid(resp_valid), .busy(busy),
    .wb_valid(wb_valid), .wb_line(wb_line), .wb_ack(wb_ack),
    .rd_count(rd_count), .wb_count(wb_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] t;
    reset = 1'b1; req = 1'b0; req_addr = '0; req_tag = '0; wb_valid = 1'b0; wb_line = '0;
    tick();
    chk("rst_resp_line", 32'(resp_line), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wb_ack", 32'(wb_ack), 32'h0);
    chk("rst_rd_count", 32'(rd_count), 32'h0);
    chk("rst_wb_count", 32'(wb_count), 32'h0);
    reset = 1'b0;
    tick();

    // 1: power-up content, 3-edge latency
    req = 1'b1; req_addr = 3'd1; req_tag = 8'h6C;
    tick();
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_valid_e1", 32'(resp_valid), 32'h0);
    tick();
    chk("t1_valid_e2", 32'(resp_valid), 32'h0);
    tick();
    chk("t1_valid_e3", 32'(resp_valid), 32'h1);
    chk("t1_line", 32'(resp_line), 32'({8'h6C, 3'b001}));
    chk("t1_rd_count", 32'(rd_count), 32'd1);
    req = 1'b0;
    tick();
    chk("t1_line_clr", 32'(resp_line), 32'h0);
    chk("t1_valid_clr", 32'(resp_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'h0);

    // 2: write-back then read it; write-back during RESP leaves held line alone
    wb_valid = 1'b1; wb_line = {2'd0, 8'h64, 3'b101};
    tick();
    wb_valid = 1'b0;
    chk("t2_wb_ack", 32'(wb_ack), 32'h1);
    chk("t2_wb_count", 32'(wb_count), 32'd1);
    req = 1'b1; req_addr = 3'd0; req_tag = 8'h64;
    tick();
    chk("t2_wb_ack_once", 32'(wb_ack), 32'h0);
    tick(); tick();
    chk("t2_line", 32'(resp_line), 32'(11'b01100100_101));
    wb_valid = 1'b1; wb_line = {2'd0, 8'h64, 3'b010};
    tick();
    wb_valid = 1'b0;
    chk("t2_line_held", 32'(resp_line), 32'(11'b01100100_101));
    req = 1'b0;
    tick();

    // 3: write-back coincides with the response read -> forwarded
    req = 1'b1; req_addr = 3'd3; req_tag = 8'h76;
    tick(); tick();
    wb_valid = 1'b1; wb_line = {2'd3, 8'h76, 3'b110};
    tick();
    wb_valid = 1'b0;
    chk("t3_valid", 32'(resp_valid), 32'h1);
    chk("t3_line_fwd", 32'(resp_line), 32'({8'h76, 3'b110}));
    chk("t3_wb_count", 32'(wb_count), 32'd3);
    req = 1'b0;
    tick();

    // 4: abort in WAIT -> DRAIN -> IDLE; then a normal request with inputs changed mid-WAIT
    req = 1'b1; req_addr = 3'd2; req_tag = 8'h11;
    tick();
    req = 1'b0;
    tick();
    chk("t4_drain_busy", 32'(busy), 32'h1);
    chk("t4_drain_valid", 32'(resp_valid), 32'h0);
    tick();
    chk("t4_idle", 32'(busy), 32'h0);
    chk("t4_valid_never", 32'(resp_valid), 32'h0);
    chk("t4_rd_count", 32'(rd_count), 32'd3);
    req = 1'b1; req_addr = 3'd2; req_tag = 8'h11;
    tick();
    req_tag = 8'hAA; req_addr = 3'd1;
    tick(); tick();
    chk("t4_valid", 32'(resp_valid), 32'h1);
    chk("t4_line", 32'(resp_line), 32'({8'h11, 3'b110}));
    chk("t4_rd_count2", 32'(rd_count), 32'd4);
    req = 1'b0;
    tick();

    // 5: async reset while in RESP; array survives
    req = 1'b1; req_addr = 3'd1; req_tag = 8'h6C;
    tick(); tick(); tick();
    chk("t5_in_resp", 32'(resp_valid), 32'h1);
    #1 reset = 1'b1;
    #1;
    chk("t5_async_valid", 32'(resp_valid), 32'h0);
    chk("t5_async_line", 32'(resp_line), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    req = 1'b0;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t5_stay_idle", 32'(busy), 32'h0);
    chk("t5_no_late", 32'(resp_valid), 32'h0);
    req = 1'b1; req_addr = 3'd0; req_tag = 8'h64;
    tick(); tick(); tick();
    chk("t5_retained", 32'(resp_line), 32'({8'h64, 3'b010}));
    chk("t5_rd_count", 32'(rd_count), 32'd1);
    req = 1'b0;
    tick();

    // 6: 255 more back-to-back pairs -> rd_count wraps to 0
    for (int i = 0; i < 255; i++) begin
      t = 8'hC0 | 8'(i[5:0]);
      req = 1'b1; req_addr = 3'(i); req_tag = t;
      tick();
      req_tag = ~t;
      tick(); tick();
      chk("t6_line", 32'(resp_line), 32'({t, t[0], 2'(i)}));
      req = 1'b0;
      tick();
    end
    chk("t6_rd_wrap", 32'(rd_count), 32'd0);
    chk("t6_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
